// File: rtl/ibuffer_pkg.sv
// ibuffer_pkg
//   Shared definitions for the per-PE instruction buffer:
//   - state_e        : sequencer state encoding (IDLE / RUN / DONE)
//   - ibuffer_depth  : memory depth for a given address width
package ibuffer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int unsigned ibuffer_depth(input int unsigned addr_len);
      return 32'd1 << addr_len;
   endfunction

endpackage

// File: rtl/ibuffer_ram.sv
// ibuffer_ram
//   Simple dual-port instruction RAM: one synchronous write port and one
//   registered read port gated by a read enable. The read register holds its
//   value while re is low.
//   Ports:
//     clk          clock, rising edge
//     we/waddr/wdata  write port
//     re/raddr     read enable / read address
//     rdata        registered read data
module ibuffer_ram
   import ibuffer_pkg::*;
#(
   parameter int addrLen = 5,
   parameter int dataLen = 32
) (
   input  logic               clk,
   input  logic               we,
   input  logic [addrLen-1:0] waddr,
   input  logic [dataLen-1:0] wdata,
   input  logic               re,
   input  logic [addrLen-1:0] raddr,
   output logic [dataLen-1:0] rdata
);

   localparam int unsigned DEPTH = ibuffer_depth(addrLen);

   logic [dataLen-1:0] mem_q [DEPTH];
   logic [dataLen-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ibuffer_seq.sv
// ibuffer_seq
//   Per-PE instruction buffer with a run-time write port and an internal
//   program counter that walks [startAddr..endAddr] (wrapping modulo DEPTH)
//   numIter times, issuing one instruction per non-stalled cycle.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; writes accepted
//   RUN   | issuing window; writes rejected with a wrErr pulse
//   DONE  | one-cycle done pulse; writes accepted, start ignored
//
//   Ports:
//     clk, reset                  clock / async active-high reset
//     wrEn, wrAddr, wrData, wrErr instruction write port, reject pulse
//     start, startAddr, endAddr, numIter  sequence launch
//     noStall                     pipeline advance
//     dataOut, instValid, pc      issued instruction, valid, next address
//     busy, done                  RUN indicator, end-of-sequence pulse
module ibuffer_seq
   import ibuffer_pkg::*;
#(
   parameter int addrLen = 5,
   parameter int dataLen = 32,
   parameter int iterLen = 8,
   parameter int peId    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wrEn,
   input  logic [addrLen-1:0] wrAddr,
   input  logic [dataLen-1:0] wrData,
   output logic               wrErr,
   input  logic               start,
   input  logic [addrLen-1:0] startAddr,
   input  logic [addrLen-1:0] endAddr,
   input  logic [iterLen-1:0] numIter,
   input  logic               noStall,
   output logic [dataLen-1:0] dataOut,
   output logic               instValid,
   output logic [addrLen-1:0] pc,
   output logic               busy,
   output logic               done
);

   // peId only tags the instance; reject nonsense values at elaboration.
   if (peId < 0) begin : g_pe_id_check
      $error("ibuffer_seq: peId must be non-negative");
   end

   state_e             state_q, state_d;
   logic [addrLen-1:0] pc_q, pc_d;
   logic [addrLen-1:0] start_addr_q, start_addr_d;
   logic [addrLen-1:0] end_addr_q, end_addr_d;
   logic [iterLen-1:0] iter_cnt_q, iter_cnt_d;
   logic               inst_valid_q, inst_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wr_err_q, wr_err_d;
   logic               has_data_q, has_data_d;

   logic               issue;
   logic               ram_we;
   logic [dataLen-1:0] ram_rdata;

   assign issue  = (state_q == RUN) && noStall;
   assign ram_we = wrEn && (state_q != RUN);

   ibuffer_ram #(
      .addrLen (addrLen),
      .dataLen (dataLen)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wrAddr),
      .wdata (wrData),
      .re    (issue),
      .raddr (pc_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      start_addr_d = start_addr_q;
      end_addr_d   = end_addr_q;
      iter_cnt_d   = iter_cnt_q;
      inst_valid_d = inst_valid_q;
      has_data_d   = has_data_q;
      done_d       = 1'b0;
      wr_err_d     = wrEn && (state_q == RUN);

      // Valid follows issue whenever the pipeline advances; a stall freezes it.
      if (noStall) inst_valid_d = issue;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = RUN;
               start_addr_d = startAddr;
               end_addr_d   = endAddr;
               pc_d         = startAddr;
               iter_cnt_d   = (numIter == '0) ? '0 : numIter - 1'b1;
            end
         end
         RUN: begin
            if (noStall) begin
               has_data_d = 1'b1;
               if (pc_q != end_addr_q) begin
                  pc_d = pc_q + 1'b1;
               end else if (iter_cnt_q != '0) begin
                  pc_d       = start_addr_q;
                  iter_cnt_d = iter_cnt_q - 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         start_addr_q <= '0;
         end_addr_q   <= '0;
         iter_cnt_q   <= '0;
         inst_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         wr_err_q     <= 1'b0;
         has_data_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         start_addr_q <= start_addr_d;
         end_addr_q   <= end_addr_d;
         iter_cnt_q   <= iter_cnt_d;
         inst_valid_q <= inst_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         wr_err_q     <= wr_err_d;
         has_data_q   <= has_data_d;
      end
   end

   // The RAM read register has no reset; mask it until the first issue so
   // dataOut reads zero out of reset.
   assign dataOut   = has_data_q ? ram_rdata : '0;
   assign instValid = inst_valid_q;
   assign pc        = pc_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wrErr     = wr_err_q;

endmodule
